// File: rtl/pipe_prbs_check.sv
// rtl/pipe_prbs_check.sv - pattern checker (counter / LFSR / walking-one) for a pipe data stream
// Define PIPE_CHECK_FIRST_ERR_EN to capture index and data of the first mismatching word.
module pipe_prbs_check #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             throttle_set,
  input  logic [31:0]      throttle_val,
  input  logic             pipe_in_write,
  input  logic [WIDTH-1:0] pipe_in_data,
  output logic             pipe_in_ready,
  output logic [15:0]      error_count,
  output logic [31:0]      word_count,
  output logic             overrun,
  output logic             first_err_valid,
  output logic [31:0]      first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [1:0]  MODE_LFSR = 2'd1;
  localparam logic [1:0]  MODE_WALK = 2'd2;

  logic [1:0]       mode_q;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] pat_next;
  logic [WIDTH-1:0] pat_start;
  logic [WIDTH-1:0] lfsr_word;
  logic [WIDTH-1:0] expected;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_next;
  logic [31:0]      throttle_q;
  logic             mismatch;
  logic             accept;

  // pat_q serves both counter and walking-one; the start value follows the incoming mode
  assign pat_start = (mode == MODE_WALK) ? WIDTH'(1) : '0;
  assign pat_next  = (mode_q == MODE_WALK) ? {pat_q[WIDTH-2:0], pat_q[WIDTH-1]}
                                           : pat_q + WIDTH'(1);
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  generate
    if (WIDTH == 16) begin : g_lfsr16
      assign lfsr_word = lfsr_q[15:0];
    end else if (WIDTH == 32) begin : g_lfsr32
      assign lfsr_word = lfsr_q;
    end else begin : g_lfsr64
      assign lfsr_word = {lfsr_q, lfsr_q};
    end
  endgenerate

  assign expected = (mode_q == MODE_LFSR) ? lfsr_word : pat_q;
  assign mismatch = (pipe_in_data != expected);
  assign accept   = pipe_in_write && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= mode;
      pat_q       <= pat_start;
      lfsr_q      <= LFSR_SEED;
      word_count  <= 32'h0;
      error_count <= 16'h0;
      overrun     <= 1'b0;
    end else if (clear) begin
      mode_q      <= mode;
      pat_q       <= pat_start;
      lfsr_q      <= LFSR_SEED;
      word_count  <= 32'h0;
      error_count <= 16'h0;
      overrun     <= 1'b0;
    end else if (pipe_in_write) begin
      pat_q      <= pat_next;
      lfsr_q     <= lfsr_next;
      word_count <= word_count + 32'd1;
      if (mismatch && (error_count != 16'hFFFF)) begin
        error_count <= error_count + 16'd1;
      end
      if (!pipe_in_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  // Throttle ring is independent of clear so a sink pattern survives a test restart
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      throttle_q <= 32'hFFFF_FFFF;
    end else if (throttle_set) begin
      throttle_q <= throttle_val;
    end else begin
      throttle_q <= {throttle_q[0], throttle_q[31:1]};
    end
  end

  assign pipe_in_ready = throttle_q[0];

`ifdef PIPE_CHECK_FIRST_ERR_EN
  logic             fe_valid_q;
  logic [31:0]      fe_idx_q;
  logic [WIDTH-1:0] fe_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fe_valid_q <= 1'b0;
      fe_idx_q   <= 32'h0;
      fe_data_q  <= '0;
    end else if (clear) begin
      fe_valid_q <= 1'b0;
      fe_idx_q   <= 32'h0;
      fe_data_q  <= '0;
    end else if (accept && mismatch && !fe_valid_q) begin
      fe_valid_q <= 1'b1;
      fe_idx_q   <= word_count;
      fe_data_q  <= pipe_in_data;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_idx   = fe_idx_q;
  assign first_err_data  = fe_data_q;
`else
  assign first_err_valid = 1'b0;
  assign first_err_idx   = 32'h0;
  assign first_err_data  = '0;
`endif

endmodule

// File: tb/tb_pipe_prbs_check.sv
// tb/tb_pipe_prbs_check.sv - scoreboard bench for pipe_prbs_check
module tb_pipe_prbs_check;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [1:0]  mode;
  logic        throttle_set;
  logic [31:0] throttle_val;
  logic        pipe_in_write;
  logic [31:0] pipe_in_data;
  logic        pipe_in_ready;
  logic [15:0] error_count;
  logic [31:0] word_count;
  logic        overrun;
  logic        first_err_valid;
  logic [31:0] first_err_idx;
  logic [31:0] first_err_data;

  logic        w16;
  logic [15:0] d16;
  logic        ready16;
  logic [15:0] ec16;
  logic [31:0] wc16;
  logic        ov16;
  logic        fv16;
  logic [31:0] fi16;
  logic [15:0] fd16;

  pipe_prbs_check #(.WIDTH(32), .LFSR_SEED(32'h0000_0001)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
    .throttle_set(throttle_set), .throttle_val(throttle_val),
    .pipe_in_write(pipe_in_write), .pipe_in_data(pipe_in_data),
    .pipe_in_ready(pipe_in_ready), .error_count(error_count), .word_count(word_count),
    .overrun(overrun), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data)
  );

  pipe_prbs_check #(.WIDTH(16), .LFSR_SEED(32'h0000_0001)) dut16 (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .mode(2'd0),
    .throttle_set(1'b0), .throttle_val(32'h0),
    .pipe_in_write(w16), .pipe_in_data(d16),
    .pipe_in_ready(ready16), .error_count(ec16), .word_count(wc16),
    .overrun(ov16), .first_err_valid(fv16),
    .first_err_idx(fi16), .first_err_data(fd16)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [48:0] counts;
    logic [64:0] first;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_item;

  logic [1:0]  m_mode;
  logic [31:0] m_exp;
  logic [31:0] m_lfsr;
  logic [31:0] m_wc;
  logic [15:0] m_ec;
  logic        m_ov;
  logic        m_fv;
  logic [31:0] m_fidx;
  logic [31:0] m_fdata;
  logic [31:0] m_thr;
  logic        pending = 1'b0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic model_restart();
    m_mode  = mode;
    m_lfsr  = 32'h0000_0001;
    m_exp   = (m_mode == 2'd1) ? m_lfsr : ((m_mode == 2'd2) ? 32'h1 : 32'h0);
    m_wc    = 0;
    m_ec    = 0;
    m_ov    = 0;
    m_fv    = 0;
    m_fidx  = 0;
    m_fdata = 0;
  endtask

  // Sink ready model: reset to all ones, load on throttle_set, otherwise rotate right
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_thr <= 32'hFFFF_FFFF;
    else if (throttle_set) m_thr <= throttle_val;
    else m_thr <= {m_thr[0], m_thr[31:1]};
  end

  task automatic do_write(input logic [31:0] d);
    sb_t it;
    pipe_in_write = 1'b1;
    pipe_in_data  = d;
    if (d !== m_exp) begin
      if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
      if (!m_fv) begin
        m_fv    = 1'b1;
        m_fidx  = m_wc;
        m_fdata = d;
      end
    end
    if (!m_thr[0]) m_ov = 1'b1;
    m_wc = m_wc + 32'd1;
    case (m_mode)
      2'd1: begin m_lfsr = lfsr_step(m_lfsr); m_exp = m_lfsr; end
      2'd2: m_exp = {m_exp[30:0], m_exp[31]};
      default: m_exp = m_exp + 32'd1;
    endcase
    it.counts = {m_ov, m_ec, m_wc};
`ifdef PIPE_CHECK_FIRST_ERR_EN
    it.first = {m_fv, m_fidx, m_fdata};
`else
    it.first = '0;
`endif
    sb_q.push_back(it);
    @(negedge clk);
    pipe_in_write = 1'b0;
  endtask

  task automatic do_clear(input logic [1:0] md, input logic with_write, input logic [31:0] d);
    mode          = md;
    clear         = 1'b1;
    pipe_in_write = with_write;
    pipe_in_data  = d;
    model_restart();
    @(negedge clk);
    clear         = 1'b0;
    pipe_in_write = 1'b0;
  endtask

  always @(posedge clk) pending <= pipe_in_write && !clear && reset_n;

  always @(negedge clk) begin
    if (pending) begin
      check("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) begin
        sb_item = sb_q.pop_front();
        check("counts", {overrun, error_count, word_count}, sb_item.counts);
        check("first", {first_err_valid, first_err_idx, first_err_data}, sb_item.first);
      end
    end
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; mode = 2'd0;
    throttle_set = 1'b0; throttle_val = 32'h0;
    pipe_in_write = 1'b0; pipe_in_data = 32'h0;
    w16 = 1'b0; d16 = 16'h0;
    model_restart();
    repeat (2) @(negedge clk);
    check("rst_ready", pipe_in_ready, 1);
    check("rst_counts", {overrun, error_count, word_count}, 0);
    check("rst_first", {first_err_valid, first_err_idx, first_err_data}, 0);
    check("rst16_counts", {ready16, ov16, ec16, wc16}, {1'b1, 49'h0});
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 1000; i++) do_write(32'(i));
    check("cnt1000", {overrun, error_count, word_count}, {1'b0, 16'd0, 32'd1000});

    do_clear(2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) do_write((i == 5) ? 32'hDEAD_BEEF : 32'(i));
    check("bad5_ec", error_count, 1);
`ifdef PIPE_CHECK_FIRST_ERR_EN
    check("bad5_first", {first_err_valid, first_err_idx, first_err_data}, {1'b1, 32'd5, 32'hDEAD_BEEF});
`else
    check("bad5_first", {first_err_valid, first_err_idx, first_err_data}, 0);
`endif

    // Walking-one through a wrap; a mode change without clear must be ignored
    do_clear(2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 70; i++) begin
      if (i == 10) mode = 2'd1;
      do_write((i == 40) ? 32'h0 : m_exp);
    end
    check("walk_ec", error_count, 1);

    do_clear(2'd1, 1'b0, 32'h0);
    do_write(32'h0000_0001);
    do_write(32'h8020_0003);
    do_write(32'hC030_0002);
    for (int i = 0; i < 60; i++) do_write((i == 33) ? ~m_exp : m_exp);
    check("lfsr_ec", error_count, 1);

    do_clear(2'd3, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) do_write(32'(i));
    check("mode3_ec", error_count, 0);

    do_clear(2'd0, 1'b0, 32'h0);
    throttle_set = 1'b1; throttle_val = 32'h0000_00F0;
    @(negedge clk);
    throttle_set = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check("ready_seq", pipe_in_ready, 128'(((k % 32) >= 4) && ((k % 32) <= 7)));
      if (k == 1) do_write(m_exp);
      else @(negedge clk);
    end
    check("overrun", overrun, 1);
    throttle_set = 1'b1; throttle_val = 32'hFFFF_FFFF;
    @(negedge clk);
    throttle_set = 1'b0;

    for (int i = 0; i < 7; i++) do_write(m_exp);
    do_clear(2'd0, 1'b1, 32'h1234_5678);
    check("clr_counts", {overrun, error_count, word_count}, 0);
    for (int i = 0; i < 5; i++) do_write(32'(i));

    do_write(m_exp);
    do_write(32'hFFFF_0000);
    #2;
    reset_n = 1'b0;
    mode = 2'd2;
    #1;
    check("arst_counts", {overrun, error_count, word_count}, 0);
    check("arst_first", {first_err_valid, first_err_idx, first_err_data}, 0);
    check("arst_ready", pipe_in_ready, 1);
    model_restart();
    @(negedge clk);
    reset_n = 1'b1;
    do_write(32'h1);
    do_write(32'h2);
    do_write(32'h4);
    check("arst_ec", error_count, 0);

    // Saturation on the 32-bit checker while the 16-bit one wraps its counter
    do_clear(2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 65537; i++) begin
      w16 = 1'b1;
      d16 = 16'(i);
      do_write(m_exp ^ 32'h1);
    end
    w16 = 1'b0;
    check("sat_ec", error_count, 16'hFFFF);
    check("w16_ec", ec16, 0);
    check("w16_wc", wc16, 65537);
    check("w16_ov", ov16, 0);

    @(negedge clk);
    check("sb_drain", 128'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
